// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the front-end hazard sequencer.
// Holds the control state enum, the scoreboard counter width and the stall-counter saturation.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      FLUSH,
      DRAIN,
      HALT
   } state_e;

   localparam int WB_LAT_DEF  = 3;
   localparam int MEM_LAT_DEF = 2;
   localparam int SB_W        = $clog2(WB_LAT_DEF + MEM_LAT_DEF + 1);

   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == STALL_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register write-back down-counters with one load port, two busy lookups and an all-idle flag.
// A counter of 1 marks the write-back cycle itself, which is bypassed to readers and so is not busy.
module reg_scoreboard
   import pipe_ctrl_pkg::*;
#(
   parameter int IDX_BITS = 4,
   parameter int CNT_W    = SB_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ld_i,
   input  logic [IDX_BITS-1:0] ld_idx_i,
   input  logic [CNT_W-1:0]    ld_val_i,
   input  logic [IDX_BITS-1:0] rd0_idx_i,
   input  logic [IDX_BITS-1:0] rd1_idx_i,
   output logic                rd0_busy_o,
   output logic                rd1_busy_o,
   output logic                idle_o
);

   localparam int N = 2 ** IDX_BITS;

   logic [CNT_W-1:0] cnt_q [N];
   logic [CNT_W-1:0] cnt_d [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
         if (ld_i && (ld_idx_i == IDX_BITS'(i))) begin
            cnt_d[i] = ld_val_i;
         end
      end
   end

   // NOTE: every counter is reset, not just the state; a stale count after reset would stall a fresh program.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign rd0_busy_o = (cnt_q[rd0_idx_i] > CNT_W'(1));
   assign rd1_busy_o = (cnt_q[rd1_idx_i] > CNT_W'(1));

   always_comb begin
      idle_o = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (cnt_q[i] != '0) begin
            idle_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Fetch/decode front-end sequencer: RAW stalls from int/vector scoreboards, jump flushes,
// and end-of-program drain to a sticky halt.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REGI_BITS = 4,
   parameter int VECT_BITS = 2,
   parameter int REGI_SIZE = 16,
   parameter int WB_LAT    = WB_LAT_DEF,
   parameter int MEM_LAT   = MEM_LAT_DEF,
   parameter int FLUSH_CYC = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 id_valid_i,
   input  logic [REGI_BITS-1:0] id_src1_i,
   input  logic                 id_src1_int_i,
   input  logic                 id_src1_v_i,
   input  logic [REGI_BITS-1:0] id_src2_i,
   input  logic                 id_src2_int_i,
   input  logic                 id_src2_v_i,
   input  logic [REGI_BITS-1:0] id_dst_i,
   input  logic                 id_wr_int_i,
   input  logic                 id_wr_v_i,
   input  logic                 id_mem_read_i,
   input  logic                 id_jump_i,
   input  logic [9:0]           id_jump_addr_i,
   input  logic                 id_end_i,
   output logic                 pc_we_o,
   output logic                 pc_sel_o,
   output logic [REGI_SIZE-1:0] pc_target_o,
   output logic                 ifid_we_o,
   output logic                 ifid_flush_o,
   output logic                 idex_bubble_o,
   output logic                 halted_o,
   output logic [15:0]          stall_cnt_o
);

   localparam int CNT_W = $clog2(WB_LAT + MEM_LAT + 1);
   localparam int FL_W  = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);

   state_e          state_q, state_d;
   logic [FL_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [15:0]     stall_cnt_q, stall_cnt_d;

   logic i_busy1, i_busy2, i_idle;
   logic v_busy1, v_busy2, v_idle;
   logic hazard, issue;
   logic [CNT_W-1:0] ld_val;

   assign ld_val = id_mem_read_i ? CNT_W'(WB_LAT + MEM_LAT) : CNT_W'(WB_LAT);

   reg_scoreboard #(.IDX_BITS(REGI_BITS), .CNT_W(CNT_W)) u_sb_int (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .ld_i       (issue && id_wr_int_i),
      .ld_idx_i   (id_dst_i),
      .ld_val_i   (ld_val),
      .rd0_idx_i  (id_src1_i),
      .rd1_idx_i  (id_src2_i),
      .rd0_busy_o (i_busy1),
      .rd1_busy_o (i_busy2),
      .idle_o     (i_idle)
   );

   reg_scoreboard #(.IDX_BITS(VECT_BITS), .CNT_W(CNT_W)) u_sb_vec (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .ld_i       (issue && id_wr_v_i),
      .ld_idx_i   (id_dst_i[VECT_BITS-1:0]),
      .ld_val_i   (ld_val),
      .rd0_idx_i  (id_src1_i[VECT_BITS-1:0]),
      .rd1_idx_i  (id_src2_i[VECT_BITS-1:0]),
      .rd0_busy_o (v_busy1),
      .rd1_busy_o (v_busy2),
      .idle_o     (v_idle)
   );

   assign hazard = id_valid_i &&
                   ((id_src1_int_i && i_busy1) || (id_src1_v_i && v_busy1) ||
                    (id_src2_int_i && i_busy2) || (id_src2_v_i && v_busy2));
   assign issue  = (state_q == RUN) && id_valid_i && !hazard;

   assign pc_target_o = REGI_SIZE'(id_jump_addr_i);
   assign stall_cnt_o = stall_cnt_q;

   // NOTE: every output and next-state signal gets a default first so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      stall_cnt_d   = stall_cnt_q;
      pc_we_o       = 1'b0;
      pc_sel_o      = 1'b0;
      ifid_we_o     = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      halted_o      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = RUN;
         end
         RUN: begin
            ifid_flush_o  = 1'b0;
            idex_bubble_o = 1'b0;
            if (hazard) begin
               idex_bubble_o = 1'b1;
               stall_cnt_d   = sat_inc(stall_cnt_q);
            end else if (issue && id_jump_i) begin
               pc_we_o      = 1'b1;
               pc_sel_o     = 1'b1;
               ifid_we_o    = 1'b1;
               ifid_flush_o = 1'b1;
               flush_cnt_d  = FL_W'(FLUSH_CYC);
               state_d      = FLUSH;
            end else if (issue && id_end_i) begin
               ifid_flush_o = 1'b1;
               state_d      = DRAIN;
            end else begin
               pc_we_o   = 1'b1;
               ifid_we_o = 1'b1;
            end
         end
         FLUSH: begin
            pc_we_o   = 1'b1;
            ifid_we_o = 1'b1;
            if (flush_cnt_q <= FL_W'(1)) state_d = RUN;
            else flush_cnt_d = flush_cnt_q - FL_W'(1);
         end
         DRAIN: begin
            if (i_idle && v_idle) state_d = HALT;
         end
         HALT: begin
            halted_o = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a time-stamp reference model.
// The model tracks the absolute cycle at which each register's write-back happens.
module tb_pipe_hazard_ctrl;

   localparam int WB_LAT    = 3;
   localparam int MEM_LAT   = 2;
   localparam int FLUSH_CYC = 1;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i, id_valid_i;
   logic [3:0]  id_src1_i, id_src2_i, id_dst_i;
   logic        id_src1_int_i, id_src1_v_i, id_src2_int_i, id_src2_v_i;
   logic        id_wr_int_i, id_wr_v_i, id_mem_read_i, id_jump_i, id_end_i;
   logic [9:0]  id_jump_addr_i;
   logic        pc_we_o, pc_sel_o, ifid_we_o, ifid_flush_o, idex_bubble_o, halted_o;
   logic [15:0] pc_target_o, stall_cnt_o;

   pipe_hazard_ctrl #(
      .REGI_BITS(4), .VECT_BITS(2), .REGI_SIZE(16),
      .WB_LAT(WB_LAT), .MEM_LAT(MEM_LAT), .FLUSH_CYC(FLUSH_CYC)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .id_valid_i(id_valid_i),
      .id_src1_i(id_src1_i), .id_src1_int_i(id_src1_int_i), .id_src1_v_i(id_src1_v_i),
      .id_src2_i(id_src2_i), .id_src2_int_i(id_src2_int_i), .id_src2_v_i(id_src2_v_i),
      .id_dst_i(id_dst_i), .id_wr_int_i(id_wr_int_i), .id_wr_v_i(id_wr_v_i),
      .id_mem_read_i(id_mem_read_i), .id_jump_i(id_jump_i), .id_jump_addr_i(id_jump_addr_i),
      .id_end_i(id_end_i), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .pc_target_o(pc_target_o),
      .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
      .halted_o(halted_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit       rst, start, valid;
      bit [3:0] s1;  bit s1i, s1v;
      bit [3:0] s2;  bit s2i, s2v;
      bit [3:0] dst; bit wi, wv, mem, jump, en;
      bit [9:0] addr;
   } stim_t;

   typedef enum {M_IDLE, M_RUN, M_FLUSH, M_DRAIN, M_HALT} mode_e;

   int     n_checks = 0;
   int     n_errors = 0;
   longint cyc = 1;
   mode_e  m_mode = M_IDLE;
   int     m_flush_left = 0;
   int     m_stall = 0;
   longint wb_int [16];
   longint wb_v [4];

   logic        obs_pc_we, obs_pc_sel, obs_flush, obs_bubble, obs_halted;
   logic [15:0] obs_target, obs_stall;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic stim_t nop();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   function automatic longint lat(input bit mem);
      return mem ? longint'(WB_LAT + MEM_LAT) : longint'(WB_LAT);
   endfunction

   // A reader at cycle c stalls while c is before the producer's write-back cycle.
   function automatic bit src_pending(input bit is_int, input bit is_v, input bit [3:0] idx);
      bit [1:0] vi;
      vi = idx[1:0];
      return (is_int && wb_int[idx] > cyc) || (is_v && wb_v[vi] > cyc);
   endfunction

   function automatic bit all_written();
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < 16; i++) if (wb_int[i] >= cyc) ok = 1'b0;
      for (int i = 0; i < 4; i++)  if (wb_v[i] >= cyc)   ok = 1'b0;
      return ok;
   endfunction

   task automatic step(input stim_t s);
      bit e_we, e_sel, e_ifwe, e_fl, e_bub, e_halt, haz, iss;
      bit [1:0] vd;
      rst_i = s.rst; start_i = s.start; id_valid_i = s.valid;
      id_src1_i = s.s1; id_src1_int_i = s.s1i; id_src1_v_i = s.s1v;
      id_src2_i = s.s2; id_src2_int_i = s.s2i; id_src2_v_i = s.s2v;
      id_dst_i = s.dst; id_wr_int_i = s.wi; id_wr_v_i = s.wv; id_mem_read_i = s.mem;
      id_jump_i = s.jump; id_jump_addr_i = s.addr; id_end_i = s.en;
      @(negedge clk_i);

      e_we = 0; e_sel = 0; e_ifwe = 0; e_fl = 1; e_bub = 1; e_halt = 0;
      haz = s.valid && (src_pending(s.s1i, s.s1v, s.s1) || src_pending(s.s2i, s.s2v, s.s2));
      iss = 0;
      if (!s.rst) begin
         case (m_mode)
            M_RUN: begin
               iss = s.valid && !haz;
               if (haz)                   begin e_fl = 0; end
               else if (iss && s.jump)    begin e_we = 1; e_sel = 1; e_ifwe = 1; e_bub = 0; end
               else if (iss && s.en)      begin e_bub = 0; end
               else                       begin e_we = 1; e_ifwe = 1; e_fl = 0; e_bub = 0; end
            end
            M_FLUSH: begin e_we = 1; e_ifwe = 1; end
            M_HALT:  e_halt = 1;
            default: ;
         endcase
      end
      check("pc_we", pc_we_o, e_we);
      check("pc_sel", pc_sel_o, e_sel);
      check("ifid_we", ifid_we_o, e_ifwe);
      check("ifid_flush", ifid_flush_o, e_fl);
      check("idex_bubble", idex_bubble_o, e_bub);
      check("halted", halted_o, e_halt);
      check("pc_target", pc_target_o, longint'(s.addr));
      check("stall_cnt", stall_cnt_o, s.rst ? 0 : m_stall);
      obs_pc_we = pc_we_o; obs_pc_sel = pc_sel_o; obs_flush = ifid_flush_o;
      obs_bubble = idex_bubble_o; obs_halted = halted_o; obs_target = pc_target_o;
      obs_stall = stall_cnt_o;

      if (s.rst) begin
         m_mode = M_IDLE; m_stall = 0;
         for (int i = 0; i < 16; i++) wb_int[i] = cyc;
         for (int i = 0; i < 4; i++)  wb_v[i] = cyc;
      end else begin
         case (m_mode)
            M_IDLE: if (s.start) m_mode = M_RUN;
            M_RUN: begin
               if (haz && m_stall < 65535) m_stall++;
               if (iss) begin
                  vd = s.dst[1:0];
                  if (s.wi) wb_int[s.dst] = cyc + lat(s.mem);
                  if (s.wv) wb_v[vd] = cyc + lat(s.mem);
                  if (s.jump) begin m_mode = M_FLUSH; m_flush_left = FLUSH_CYC; end
                  else if (s.en) m_mode = M_DRAIN;
               end
            end
            M_FLUSH: begin
               m_flush_left--;
               if (m_flush_left <= 0) m_mode = M_RUN;
            end
            M_DRAIN: if (all_written()) m_mode = M_HALT;
            default: ;
         endcase
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic reset_and_start();
      stim_t s;
      s = nop(); s.rst = 1; step(s);
      s = nop(); s.start = 1; step(s);
   endtask

   initial begin
      stim_t s;
      int n;
      for (int i = 0; i < 16; i++) wb_int[i] = 0;
      for (int i = 0; i < 4; i++)  wb_v[i] = 0;
      @(posedge clk_i);
      #1;

      // 1: reset, start, then RUN outputs
      s = nop(); s.rst = 1; step(s); step(s);
      s = nop(); s.start = 1; step(s);
      check("t1_idle_pc_we", obs_pc_we, 0);
      check("t1_idle_flush", obs_flush, 1);
      step(nop());
      check("t1_run_pc_we", obs_pc_we, 1);
      check("t1_run_flush", obs_flush, 0);
      check("t1_run_stall", obs_stall, 0);

      // 2: ALU write r3 then reader of r3
      s = nop(); s.valid = 1; s.wi = 1; s.dst = 3; step(s);
      s = nop(); s.valid = 1; s.s1 = 3; s.s1i = 1;
      n = 0; step(s);
      while (obs_bubble && n < 10) begin n++; step(s); end
      check("t2_stalls", n, 2);
      check("t2_stall_cnt", obs_stall, 2);

      // 3: load r5 then reader of r5 through operand 2
      s = nop(); s.valid = 1; s.wi = 1; s.dst = 5; s.mem = 1; step(s);
      s = nop(); s.valid = 1; s.s2 = 5; s.s2i = 1;
      n = 0; step(s);
      while (obs_bubble && n < 10) begin n++; step(s); end
      check("t3_stalls", n, 4);
      check("t3_stall_cnt", obs_stall, 6);

      // 4: jump to 0x2A
      s = nop(); s.valid = 1; s.jump = 1; s.addr = 10'h02A; step(s);
      check("t4_pc_sel", obs_pc_sel, 1);
      check("t4_target", obs_target, 16'h002A);
      check("t4_flush0", obs_flush, 1);
      step(nop());
      check("t4_flush1", obs_flush, 1);
      step(nop());
      check("t4_back_run", obs_flush, 0);

      // 5: load r2 then END, drain to a sticky halt
      s = nop(); s.valid = 1; s.wi = 1; s.dst = 2; s.mem = 1; step(s);
      s = nop(); s.valid = 1; s.en = 1; step(s);
      check("t5_end_pc_we", obs_pc_we, 0);
      n = 0; s = nop(); s.start = 1; step(s);
      while (!obs_halted && n < 20) begin n++; step(s); end
      check("t5_drain_cycles", n, 5);
      for (int i = 0; i < 3; i++) begin step(s); check("t5_sticky", obs_halted, 1); end

      // 6a: reset mid-FLUSH clears the scoreboard
      reset_and_start();
      s = nop(); s.valid = 1; s.wi = 1; s.dst = 7; s.mem = 1; step(s);
      s = nop(); s.valid = 1; s.jump = 1; s.addr = 10'h155; step(s);
      s = nop(); s.rst = 1; step(s);
      check("t6a_pc_we", obs_pc_we, 0);
      check("t6a_bubble", obs_bubble, 1);
      s = nop(); s.start = 1; step(s);
      s = nop(); s.valid = 1; s.s1 = 7; s.s1i = 1; step(s);
      check("t6a_no_stall", obs_bubble, 0);

      // 6b: reset mid-DRAIN
      s = nop(); s.valid = 1; s.wv = 1; s.dst = 4'd1; s.mem = 1; step(s);
      s = nop(); s.valid = 1; s.en = 1; step(s);
      step(nop());
      s = nop(); s.rst = 1; step(s);
      check("t6b_halted", obs_halted, 0);
      s = nop(); s.start = 1; step(s);
      s = nop(); s.valid = 1; s.s1 = 4'd1; s.s1v = 1; step(s);
      check("t6b_no_stall", obs_bubble, 0);

      // random traffic over a small register window so hazards are frequent
      for (int k = 0; k < 2500; k++) begin
         s = nop();
         if (m_mode == M_HALT || m_mode == M_IDLE) s.rst = ($urandom_range(0, 7) == 0);
         else s.rst = ($urandom_range(0, 299) == 0);
         s.start = 1'($urandom_range(0, 1));
         s.valid = ($urandom_range(0, 3) != 0);
         s.s1 = 4'($urandom_range(0, 5)); s.s1i = 1'($urandom_range(0, 1)); s.s1v = ($urandom_range(0, 3) == 0);
         s.s2 = 4'($urandom_range(0, 5)); s.s2i = 1'($urandom_range(0, 1)); s.s2v = ($urandom_range(0, 3) == 0);
         s.dst = 4'($urandom_range(0, 5)); s.wi = 1'($urandom_range(0, 1)); s.wv = ($urandom_range(0, 3) == 0);
         s.mem = ($urandom_range(0, 2) == 0);
         s.jump = ($urandom_range(0, 15) == 0);
         s.en = ($urandom_range(0, 39) == 0);
         s.addr = 10'($urandom_range(0, 1023));
         step(s);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
